// File: rtl/hack_vga_scanout.sv
// hack_vga_scanout
//   VGA scan-out engine for the Hack screen. It generates horizontal and
//   vertical timing, fetches 16-bit screen words from a BRAM with one cycle
//   of read latency, and turns them into pixels. The framebuffer window
//   (FB_W x FB_H) sits at (X_OFF, Y_OFF) inside the active area. The rest of
//   the active area is border, and everything outside the active area is
//   blanking.
//
//   Pipeline:
//     stage 0  raster counters, window decode, memory read request
//     stage 1  word capture and bit select
//     stage 2  registered outputs
//   Every output is delayed by two clocks relative to the raster counters,
//   so all outputs line up with each other.
//
//   Optional feature (macro HACK_VGA_BORDER_EN):
//     defined   - active pixels outside the window drive BORDER_COLOR
//     undefined - those pixels drive bg_color; BORDER_COLOR is ignored
//
//   Ports:
//     clk                   pixel clock (clk_25)
//     rst_n                 asynchronous reset, active low
//     fg_color, bg_color    colours for screen bit 1 and screen bit 0
//     mem_addr, mem_rd      word address and read strobe toward the BRAM
//     mem_rdata             screen word; bit 0 is the leftmost pixel
//     pix                   pixel colour
//     hsync, vsync          syncs, active at HSYNC_POL / VSYNC_POL
//     in_display            active-area flag
//     frame_start           single-cycle pulse on pixel (0,0)
//     counter_x, counter_y  raster position of the pixel currently on pix
//
//   The raster counters are 10 bits wide, so H_TOTAL and V_TOTAL must not
//   exceed 1024.
//   rst_n is expected to be released synchronously to clk. Scan restarts at
//   (0,0) on the first edge after release.

module hack_vga_scanout #(
  parameter int H_ACTIVE = 640,
  parameter int H_FP     = 16,
  parameter int H_SYNC   = 96,
  parameter int H_BP     = 48,
  parameter int V_ACTIVE = 480,
  parameter int V_FP     = 10,
  parameter int V_SYNC   = 2,
  parameter int V_BP     = 33,
  parameter int FB_W     = 512,
  parameter int FB_H     = 256,
  parameter int X_OFF    = 64,
  parameter int Y_OFF    = 112,
  parameter int PIX_BITS = 3,
  parameter int ADDR_W   = 13,
  parameter bit HSYNC_POL = 1'b0,
  parameter bit VSYNC_POL = 1'b0,
  parameter logic [PIX_BITS-1:0] BORDER_COLOR = 3'b001
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic [PIX_BITS-1:0] fg_color,
  input  logic [PIX_BITS-1:0] bg_color,
  output logic [ADDR_W-1:0]   mem_addr,
  output logic                mem_rd,
  input  logic [15:0]         mem_rdata,
  output logic [PIX_BITS-1:0] pix,
  output logic                hsync,
  output logic                vsync,
  output logic                in_display,
  output logic                frame_start,
  output logic [9:0]          counter_x,
  output logic [9:0]          counter_y
);

`ifdef HACK_VGA_BORDER_EN
  localparam bit BORDER_EN = 1'b1;
`else
  localparam bit BORDER_EN = 1'b0;
`endif

  localparam int H_TOTAL       = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL       = V_ACTIVE + V_FP + V_SYNC + V_BP;
  localparam int WORDS_PER_ROW = FB_W / 16;

  localparam logic [9:0] H_LAST   = 10'(H_TOTAL - 1);
  localparam logic [9:0] V_LAST   = 10'(V_TOTAL - 1);
  localparam logic [9:0] H_ACT_L  = 10'(H_ACTIVE);
  localparam logic [9:0] V_ACT_L  = 10'(V_ACTIVE);
  localparam logic [9:0] HS_START = 10'(H_ACTIVE + H_FP);
  localparam logic [9:0] HS_END   = 10'(H_ACTIVE + H_FP + H_SYNC);
  localparam logic [9:0] VS_START = 10'(V_ACTIVE + V_FP);
  localparam logic [9:0] VS_END   = 10'(V_ACTIVE + V_FP + V_SYNC);

  localparam logic signed [10:0] X_OFF_S = 11'(X_OFF);
  localparam logic signed [10:0] Y_OFF_S = 11'(Y_OFF);
  localparam logic signed [10:0] FB_W_S  = 11'(FB_W);
  localparam logic signed [10:0] FB_H_S  = 11'(FB_H);

  // Stage 0: raster counters
  logic [9:0] cx, cy;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cx <= '0;
      cy <= '0;
    end else if (cx == H_LAST) begin
      cx <= '0;
      cy <= (cy == V_LAST) ? '0 : cy + 10'd1;
    end else begin
      cx <= cx + 10'd1;
    end
  end

  // Stage 0 decode. fx/fy go negative above and left of the window, so
  // they are signed and one bit wider than the counters.
  logic signed [10:0] fx, fy;
  logic               s0_inside, s0_active, s0_hs, s0_vs, s0_fs, s0_rd;
  logic [ADDR_W-1:0]  word_addr, addr_hold;

  assign fx        = $signed({1'b0, cx}) - X_OFF_S;
  assign fy        = $signed({1'b0, cy}) - Y_OFF_S;
  assign s0_inside = (fx >= 11'sd0) && (fx < FB_W_S) && (fy >= 11'sd0) && (fy < FB_H_S);
  assign s0_active = (cx < H_ACT_L) && (cy < V_ACT_L);
  assign s0_hs     = (cx >= HS_START && cx < HS_END) ? HSYNC_POL : ~HSYNC_POL;
  assign s0_vs     = (cy >= VS_START && cy < VS_END) ? VSYNC_POL : ~VSYNC_POL;
  assign s0_fs     = (cx == '0) && (cy == '0);
  assign s0_rd     = s0_inside && (fx[3:0] == 4'd0);
  assign word_addr = ADDR_W'(32'(fy[9:0]) * WORDS_PER_ROW + 32'(fx[9:4]));

  // Between reads the address bus keeps its last value rather than
  // following the raster.
  assign mem_rd   = s0_rd;
  assign mem_addr = s0_rd ? word_addr : addr_hold;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) addr_hold <= '0;
    else        addr_hold <= mem_addr;
  end

  // Stage 1 pipeline registers
  logic       s1_inside, s1_active, s1_hs, s1_vs, s1_fs;
  logic [3:0] s1_idx;
  logic [9:0] s1_cx, s1_cy;
  logic [15:0] word;
  logic       s1_bit;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_inside <= 1'b0;
      s1_active <= 1'b0;
      s1_hs     <= ~HSYNC_POL;
      s1_vs     <= ~VSYNC_POL;
      s1_fs     <= 1'b0;
      s1_idx    <= '0;
      s1_cx     <= '0;
      s1_cy     <= '0;
    end else begin
      s1_inside <= s0_inside;
      s1_active <= s0_active;
      s1_hs     <= s0_hs;
      s1_vs     <= s0_vs;
      s1_fs     <= s0_fs;
      s1_idx    <= fx[3:0];
      s1_cx     <= cx;
      s1_cy     <= cy;
    end
  end

  // The first pixel of each word comes straight off the BRAM bus. The word
  // is saved at the same time so the remaining 15 pixels can use it.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                             word <= '0;
    else if (s1_inside && s1_idx == 4'd0)   word <= mem_rdata;
  end

  assign s1_bit = (s1_idx == 4'd0) ? mem_rdata[0] : word[s1_idx];

  // Stage 2: colour select. fg_color and bg_color are sampled here, so a
  // change shows up on the next registered pixel.
  logic [PIX_BITS-1:0] border_col, pix_next;

  assign border_col = BORDER_EN ? BORDER_COLOR : bg_color;

  always_comb begin
    pix_next = '0;
    if (s1_active) begin
      if (s1_inside) pix_next = s1_bit ? fg_color : bg_color;
      else           pix_next = border_col;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pix         <= '0;
      hsync       <= ~HSYNC_POL;
      vsync       <= ~VSYNC_POL;
      in_display  <= 1'b0;
      frame_start <= 1'b0;
      counter_x   <= '0;
      counter_y   <= '0;
    end else begin
      pix         <= pix_next;
      hsync       <= s1_hs;
      vsync       <= s1_vs;
      in_display  <= s1_active;
      frame_start <= s1_fs;
      counter_x   <= s1_cx;
      counter_y   <= s1_cy;
    end
  end

endmodule

// File: tb/tb_hack_vga_scanout.sv
// tb_hack_vga_scanout
//   Bench for hack_vga_scanout. The DUT runs with a shrunken raster of
//   64x32 clocks and a 32x8 window, so that whole frames stay short.
//
//   Each cycle the bench model pushes the expected output for the current
//   raster position into a queue. The entry is popped and compared when the
//   DUT presents that pixel two clocks later. The bench also provides a
//   BRAM model with three contents modes:
//     0 - word N holds N
//     1 - every word is all ones
//     2 - random words

module tb_hack_vga_scanout;

  localparam int HA = 48, HF = 4, HS = 8, HB = 4;
  localparam int VA = 24, VF = 2, VS = 2, VB = 4;
  localparam int FBW = 32, FBH = 8, XO = 8, YO = 8;
  localparam int HT = HA + HF + HS + HB;
  localparam int VT = VA + VF + VS + VB;
  localparam int FRAME = HT * VT;
  localparam int WPR = FBW / 16;
  localparam int NWORDS = WPR * FBH;
  localparam logic [2:0] BORDER = 3'b001;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [2:0]  fg_color, bg_color;
  logic [12:0] mem_addr;
  logic        mem_rd;
  logic [15:0] mem_rdata = '0;
  logic [2:0]  pix;
  logic        hsync, vsync, in_display, frame_start;
  logic [9:0]  counter_x, counter_y;

  hack_vga_scanout #(
    .H_ACTIVE(HA), .H_FP(HF), .H_SYNC(HS), .H_BP(HB),
    .V_ACTIVE(VA), .V_FP(VF), .V_SYNC(VS), .V_BP(VB),
    .FB_W(FBW), .FB_H(FBH), .X_OFF(XO), .Y_OFF(YO),
    .PIX_BITS(3), .ADDR_W(13), .HSYNC_POL(1'b0), .VSYNC_POL(1'b0),
    .BORDER_COLOR(BORDER)
  ) dut (
    .clk(clk), .rst_n(rst_n), .fg_color(fg_color), .bg_color(bg_color),
    .mem_addr(mem_addr), .mem_rd(mem_rd), .mem_rdata(mem_rdata),
    .pix(pix), .hsync(hsync), .vsync(vsync), .in_display(in_display),
    .frame_start(frame_start), .counter_x(counter_x), .counter_y(counter_y)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad = 0;

  task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("[TB] FAIL %s got=%0h exp=%0h at t=%0t", tag, got, exp, $time);
    end
  endtask

  // BRAM model
  int          mode = 0;
  logic [15:0] mem_rand [NWORDS];

  function automatic logic [15:0] memWord(input logic [12:0] a);
    case (mode)
      0:       return 16'(a);
      1:       return 16'hFFFF;
      default: return mem_rand[int'(a) % NWORDS];
    endcase
  endfunction

  always @(posedge clk) if (mem_rd) mem_rdata <= memWord(mem_addr);

  // Colours as the DUT's output stage samples them
  logic [2:0] fg_s = '0, bg_s = '0;
  always @(posedge clk) begin
    fg_s <= fg_color;
    bg_s <= bg_color;
  end

  typedef struct {
    int kind;   // 0 blank, 1 border, 2 window
    bit pb;
    bit hs;
    bit vs;
    bit fs;
    int x;
    int y;
  } exp_t;

  function automatic exp_t resetItem();
    exp_t e;
    e.kind = 0; e.pb = 0; e.hs = 1; e.vs = 1; e.fs = 0; e.x = 0; e.y = 0;
    return e;
  endfunction

  function automatic exp_t modelPixel(input int x, input int y);
    exp_t e;
    int wx, wy;
    logic [15:0] w;
    wx = x - XO;
    wy = y - YO;
    e.x = x; e.y = y; e.pb = 0;
    e.fs = (x == 0 && y == 0);
    e.hs = !(x >= HA + HF && x < HA + HF + HS);
    e.vs = !(y >= VA + VF && y < VA + VF + VS);
    if (x < HA && y < VA) begin
      if (wx >= 0 && wx < FBW && wy >= 0 && wy < FBH) begin
        e.kind = 2;
        w = memWord(13'(wy * WPR + wx / 16));
        e.pb = w[wx % 16];
      end else begin
        e.kind = 1;
      end
    end else begin
      e.kind = 0;
    end
    return e;
  endfunction

  function automatic logic [26:0] packExp(input exp_t e);
    logic [2:0] col;
    case (e.kind)
      0: col = 3'b000;
`ifdef HACK_VGA_BORDER_EN
      1: col = BORDER;
`else
      1: col = bg_s;
`endif
      default: col = e.pb ? fg_s : bg_s;
    endcase
    return {col, e.hs, e.vs, e.kind != 0, e.fs, 10'(e.x), 10'(e.y)};
  endfunction

  logic [26:0] act;
  assign act = {pix, hsync, vsync, in_display, frame_start, counter_x, counter_y};

  // Per-frame statistics, collected over windows aligned to stage-0 (0,0)
  int acc_fs, acc_hs, acc_vs, acc_rd, acc_first, acc_last;
  int last_fs, last_hs, last_vs, last_rd, last_first, last_last;
  int frame_done = 0;
  bit stats_valid = 0;

  exp_t q[$];
  int   mx = 0, my = 0;

  always @(negedge clk) begin : scoreboard
    exp_t e, r;
    int wx, wy;
    bit inwin, erd;
    if (!rst_n) begin
      r = resetItem();
      q.delete();
      q.push_back(r);
      q.push_back(r);
      mx = 0; my = 0;
      stats_valid = 0;
      checkOutput("out_rst", 32'(act), 32'(packExp(r)));
      checkOutput("rd_rst", 32'({mem_rd, mem_addr}), 32'd0);
    end else begin
      wx = mx - XO;
      wy = my - YO;
      inwin = (wx >= 0 && wx < FBW && wy >= 0 && wy < FBH);
      erd = inwin && (wx % 16 == 0);
      checkOutput("rd", 32'(mem_rd), 32'(erd));
      if (erd) checkOutput("addr", 32'(mem_addr), 32'(wy * WPR + wx / 16));

      if (mx == 0 && my == 0) begin
        if (stats_valid) begin
          last_fs = acc_fs; last_hs = acc_hs; last_vs = acc_vs;
          last_rd = acc_rd; last_first = acc_first; last_last = acc_last;
          frame_done++;
        end
        stats_valid = 1;
        acc_fs = 0; acc_hs = 0; acc_vs = 0; acc_rd = 0; acc_first = -1; acc_last = -1;
      end

      q.push_back(modelPixel(mx, my));
      e = q.pop_front();
      checkOutput("out", 32'(act), 32'(packExp(e)));
      if (mode == 0 && e.x == XO && e.y == YO)      checkOutput("px_origin", 32'(pix), 32'd0);
      if (mode == 0 && e.x == XO + 16 && e.y == YO) checkOutput("px_word1", 32'(pix), 32'd7);

      if (frame_start) acc_fs++;
      if (!hsync) acc_hs++;
      if (!vsync) acc_vs++;
      if (mem_rd) begin
        if (acc_rd == 0) acc_first = int'(mem_addr);
        acc_last = int'(mem_addr);
        acc_rd++;
      end

      if (mx == HT - 1) begin
        mx = 0;
        my = (my == VT - 1) ? 0 : my + 1;
      end else begin
        mx = mx + 1;
      end
    end
  end

  // Drives rst_n, memory mode and colours just after a rising edge
  task automatic applyStimulus(input logic r, input int m, input logic [2:0] f, input logic [2:0] b);
    @(posedge clk);
    #1;
    rst_n = r;
    mode = m;
    fg_color = f;
    bg_color = b;
  endtask

  task automatic checkFsLatency();
    int fs_at;
    logic [19:0] pos;
    fs_at = -1;
    pos = '1;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      #1;
      if (frame_start && fs_at < 0) begin
        fs_at = i;
        pos = {counter_x, counter_y};
      end
    end
    checkOutput("fs_latency", 32'(fs_at), 32'd2);
    checkOutput("fs_pos", 32'(pos), 32'd0);
  endtask

  task automatic waitFrame();
    int target;
    bit got;
    target = frame_done + 1;
    got = 0;
    for (int i = 0; i < 3 * FRAME && !got; i++) begin
      @(negedge clk);
      #2;
      if (frame_done >= target) got = 1;
    end
    if (!got) checkOutput("frame_timeout", 32'd0, 32'd1);
  endtask

  task automatic waitPos(input int x, input int y);
    bit got;
    got = 0;
    for (int i = 0; i < 2 * FRAME && !got; i++) begin
      @(negedge clk);
      #1;
      if (int'(counter_x) == x && int'(counter_y) == y) got = 1;
    end
    if (!got) checkOutput("pos_timeout", 32'd0, 32'd1);
  endtask

  task automatic checkStats();
    checkOutput("fs_per_frame", 32'(last_fs), 32'd1);
    checkOutput("hs_low", 32'(last_hs), 32'(HS * VT));
    checkOutput("vs_low", 32'(last_vs), 32'(VS * HT));
    checkOutput("rd_count", 32'(last_rd), 32'(NWORDS));
    checkOutput("rd_first", 32'(last_first), 32'd0);
    checkOutput("rd_last", 32'(last_last), 32'(NWORDS - 1));
  endtask

  initial begin
    foreach (mem_rand[i]) mem_rand[i] = 16'($urandom);
    rst_n = 1'b0;
    mode = 0;
    fg_color = 3'b111;
    bg_color = 3'b000;
    $display("[TB] reset, then counting-pattern memory");
    repeat (3) @(posedge clk);
    applyStimulus(1'b1, 0, 3'b111, 3'b000);
    checkFsLatency();
    waitFrame();
    checkStats();

    $display("[TB] mid-frame reset, then all-ones memory");
    waitPos(20, 12);
    applyStimulus(1'b0, 1, 3'b100, 3'b010);
    #1;
    checkOutput("rst_now", 32'({pix, hsync, vsync, in_display, frame_start, counter_x, counter_y, mem_rd}),
                32'({3'b000, 1'b1, 1'b1, 1'b0, 1'b0, 10'd0, 10'd0, 1'b0}));
    repeat (2) @(posedge clk);
    applyStimulus(1'b1, 1, 3'b100, 3'b010);
    checkFsLatency();

    $display("[TB] fg_color change inside the window");
    waitPos(XO + 4, YO + 3);
    checkOutput("fg_before", 32'(pix), 32'(3'b100));
    fg_color = 3'b110;
    @(negedge clk);
    #1;
    checkOutput("fg_after", 32'(pix), 32'(3'b110));
    waitFrame();
    checkStats();

    $display("[TB] random memory with random colours");
    applyStimulus(1'b0, 2, 3'b101, 3'b011);
    applyStimulus(1'b1, 2, 3'b101, 3'b011);
    for (int i = 0; i < FRAME + HT; i++) begin
      @(negedge clk);
      #1;
      fg_color = 3'($urandom);
      bg_color = 3'($urandom);
    end
    waitFrame();
    checkStats();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
